// File: rtl/mudv_arbiter.sv
// ============================================================================
// mudv_arbiter : round-robin shared iterative multiply/divide engine
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mudv_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   req,
    input  logic [1:0]   op,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic [1:0]   gnt,
    output logic         busy,
    output logic [1:0]   done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         dz
);

    localparam int            CW      = $clog2(N + 1);
    localparam logic [CW-1:0] C_LAST  = CW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          owner_q;
    logic          last_q;
    logic          div_q;
    logic [N-1:0]  m_q;
    logic [N-1:0]  acc_q;
    logic [N-1:0]  qp_q;

    logic          win_d;
    logic [N-1:0]  sel_a_d;
    logic [N-1:0]  sel_b_d;
    logic          sel_op_d;
    logic [N:0]    sum_d;
    logic [N:0]    sh_d;
    logic [N:0]    diff_d;
    logic [N-1:0]  acc_d;
    logic [N-1:0]  qp_d;

    assign busy = (state_q == CALC);

    // acc/qp hold {hi,lo} of the product, or {remainder,dividend->quotient}
    always_comb begin
        win_d    = (req == 2'b11) ? ~last_q : req[1];
        sel_a_d  = win_d ? a1 : a0;
        sel_b_d  = win_d ? b1 : b0;
        sel_op_d = op[win_d];

        sum_d  = {1'b0, acc_q} + {1'b0, (qp_q[0] ? m_q : {N{1'b0}})};
        sh_d   = {acc_q, qp_q[N-1]};
        diff_d = sh_d - {1'b0, m_q};

        if (div_q) begin
            acc_d = diff_d[N] ? sh_d[N-1:0] : diff_d[N-1:0];
            qp_d  = N'({qp_q, ~diff_d[N]});
        end else begin
            acc_d = sum_d[N:1];
            qp_d  = N'({sum_d[0], qp_q} >> 1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            div_q   <= 1'b0;
            m_q     <= '0;
            acc_q   <= '0;
            qp_q    <= '0;
            gnt     <= '0;
            done    <= '0;
            hi      <= '0;
            lo      <= '0;
            dz      <= 1'b0;
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        owner_q <= win_d;
                        div_q   <= sel_op_d;
                        m_q     <= sel_op_d ? sel_b_d : sel_a_d;
                        qp_q    <= sel_op_d ? sel_a_d : sel_b_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        gnt     <= win_d ? 2'b10 : 2'b01;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    qp_q  <= qp_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == C_LAST) begin
                        hi      <= acc_d;
                        lo      <= qp_d;
                        dz      <= div_q && (m_q == '0);
                        done    <= owner_q ? 2'b10 : 2'b01;
                        last_q  <= owner_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mudv_arbiter.sv
// ============================================================================
// tb_mudv_arbiter : directed self-checking bench for mudv_arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mudv_arbiter;

    localparam int N = 3;

    logic         clk;
    logic         reset_n;
    logic [1:0]   req;
    logic [1:0]   op;
    logic [N-1:0] a0, b0, a1, b1;
    logic [1:0]   gnt;
    logic         busy;
    logic [1:0]   done;
    logic [N-1:0] hi, lo;
    logic         dz;

    int vectors;
    int miscompares;

    mudv_arbiter #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .op      (op),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .dz      (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation from an IDLE edge; operands are scrambled after grant.
    task automatic run_op(input int r, input logic o, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] eh,
                          input logic [N-1:0] el, input logic ed, input string tag);
        logic [1:0] onehot;
        onehot = (r == 0) ? 2'b01 : 2'b10;
        if (r == 0) begin a0 = a; b0 = b; op[0] = o; end
        else        begin a1 = a; b1 = b; op[1] = o; end
        req[r] = 1'b1;
        tick();
        chk({tag, "/gnt"}, {gnt, done, busy}, {onehot, 2'b00, 1'b1});
        req[r] = 1'b0;
        if (r == 0) begin a0 = ~a; b0 = b + 3'd3; end
        else        begin a1 = ~a; b1 = b + 3'd3; end
        for (int i = 0; i < N - 1; i++) begin
            tick();
            chk({tag, "/calc"}, {gnt, done, busy}, 5'b00001);
        end
        tick();
        chk({tag, "/done"}, {gnt, done, busy}, {2'b00, onehot, 1'b0});
        chk({tag, "/res"}, {hi, lo, dz}, {eh, el, ed});
    endtask

    initial begin
        logic [5:0] p;
        vectors     = 0;
        miscompares = 0;
        reset_n = 1'b0;
        req = 2'b00; op = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        tick();
        chk("reset_out", {gnt, done, busy, hi, lo, dz}, 12'h000);
        tick();
        reset_n = 1'b1;

        // Contention straight out of reset: requester 0 first.
        a0 = 3'd2; b0 = 3'd3; op[0] = 1'b0;
        a1 = 3'd6; b1 = 3'd4; op[1] = 1'b1;
        req = 2'b11;
        tick();
        chk("cont_gnt0", {gnt, busy}, 3'b011);
        req[0] = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            tick();
            chk("cont_hold", {gnt, done, busy}, 5'b00001);
        end
        tick();
        chk("cont_done0", {gnt, done, busy}, 5'b00010);
        chk("cont_res0", {hi, lo, dz}, {3'd0, 3'd6, 1'b0});
        tick();
        chk("cont_gnt1", {gnt, busy}, 3'b101);
        req[1] = 1'b0;
        for (int i = 0; i < N - 1; i++) tick();
        tick();
        chk("cont_done1", {gnt, done, busy}, 5'b00100);
        chk("cont_res1", {hi, lo, dz}, {3'd2, 3'd1, 1'b0});
        req = 2'b11;
        tick();
        chk("cont_alt0", {gnt, busy}, 3'b011);
        req[0] = 1'b0;
        for (int i = 0; i < N; i++) tick();
        chk("cont_done_alt0", done, 2'b01);
        req[0] = 1'b1;
        tick();
        chk("cont_alt1", {gnt, busy}, 3'b101);
        req = 2'b00;
        for (int i = 0; i < N; i++) tick();
        chk("cont_done_alt1", done, 2'b10);

        run_op(0, 1'b0, 3'd7, 3'd7, 3'd6, 3'd1, 1'b0, "mul7x7");
        run_op(1, 1'b1, 3'd7, 3'd2, 3'd1, 3'd3, 1'b0, "div7/2");
        run_op(1, 1'b1, 3'd5, 3'd0, 3'd5, 3'd7, 1'b1, "div5/0");
        run_op(0, 1'b0, 3'd3, 3'd5, 3'd1, 3'd7, 1'b0, "hold3x5");
        run_op(0, 1'b1, 3'd6, 3'd3, 3'd0, 3'd2, 1'b0, "dz_clear");

        for (int r = 0; r < 2; r++) begin
            for (int o = 0; o < 2; o++) begin
                for (int a = 0; a < 8; a++) begin
                    for (int b = 0; b < 8; b++) begin
                        if (o == 0) begin
                            p = 6'(a * b);
                            run_op(r, 1'b0, 3'(a), 3'(b), p[5:3], p[2:0], 1'b0,
                                   $sformatf("sw_r%0d_mul_%0d_%0d", r, a, b));
                        end else if (b == 0) begin
                            run_op(r, 1'b1, 3'(a), 3'(b), 3'(a), 3'd7, 1'b1,
                                   $sformatf("sw_r%0d_div_%0d_%0d", r, a, b));
                        end else begin
                            run_op(r, 1'b1, 3'(a), 3'(b), 3'(a % b), 3'(a / b), 1'b0,
                                   $sformatf("sw_r%0d_div_%0d_%0d", r, a, b));
                        end
                    end
                end
            end
        end

        // Reset in the middle of a calculation aborts it.
        a1 = 3'd7; b1 = 3'd7; op[1] = 1'b0;
        req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        chk("abort_started", busy, 1'b1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("abort_async", {gnt, done, busy, hi, lo, dz}, 12'h000);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            tick();
            chk("abort_no_done", {gnt, done, busy}, 5'b00000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mudv_arbiter.md
# mudv_arbiter

Shares one iterative multiply/divide engine between two requesters with round-robin arbitration. It accepts one operation at a time, runs it in N clock cycles and returns a {hi, lo} result with a one-cycle done pulse to the requester that owns it. The multiply uses shift-add and the divide uses restoring division. It sits beside the switch/seven-segment front end as the sequenced, shared replacement for the single-cycle multiply/divide datapath. Its hi/lo outputs feed the existing seven_seg decoders.

## Interface
Parameters:
- N, default 3: operand width in bits; also the number of iteration cycles.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester request; bit i belongs to requester i.
- op  in  2  per-requester operation: 0 = multiply, 1 = divide.
- a0, b0  in  N each  operands of requester 0.
- a1, b1  in  N each  operands of requester 1.
- gnt  out  2  one-hot, one-cycle pulse: the request was accepted and its operands are latched.
- busy  out  1  high while an operation is executing.
- done  out  2  one-hot, one-cycle pulse to the owning requester: the result is valid.
- hi  out  N  multiply: product[2N-1:N]; divide: remainder.
- lo  out  N  multiply: product[N-1:0]; divide: quotient.
- dz  out  1  the last completed operation was a divide by zero.

## Operation
- The block has two states, IDLE and CALC, plus an iteration counter cnt of width clog2(N+1).
- IDLE:
  - req is sampled at each edge.
  - If any bit is set, the block selects a winner and latches that requester's a, b and op, plus the owner index.
  - It pulses gnt[winner], clears cnt and moves to CALC.
- Arbitration is round-robin on a last-served pointer.
  - If only one request is set, that requester wins.
  - If both are set, the requester not served last wins.
  - After reset the pointer gives requester 0 priority.
- Handshake:
  - A requester holds req, op and its operands stable until it sees gnt, then drops req.
  - Operands are latched at grant; later changes on the input ports are ignored.
  - req is only sampled in IDLE. A req still high at the next IDLE is treated as a new operation.
- Multiply uses a 2N-bit shift-add product register, one multiplier bit per cycle, unsigned.
- Divide is restoring and unsigned, producing one quotient bit per cycle.
  - b = 0 is not special-cased: the algorithm naturally yields quotient all-ones and remainder = a.
  - dz is set to 1 for that result and cleared on every other completion.
- CALC:
  - Each edge performs one iteration and increments cnt.
  - On the edge that performs iteration N, the block writes hi, lo and dz, pulses done[owner], updates the pointer to owner and returns to IDLE.
- hi, lo and dz hold their values until the next completion.
- busy = (state == CALC).

## Timing
- Reset, asynchronous: state = IDLE, cnt = 0, pointer favours requester 0. All outputs are 0: gnt, done, busy, hi, lo, dz.
- Reset asserted mid-operation aborts the operation. No done is produced and the latched operands are discarded.
- Request sampled in IDLE at edge k:
  - gnt high for the cycle after edge k;
  - busy high from edge k to edge k+N;
  - the result registers and done update at edge k+N;
  - done is high for the cycle after edge k+N.
- The block is back in IDLE after edge k+N and can accept at edge k+N+1. Throughput is one operation per N+1 cycles.
- gnt and done are registered and never high in the same cycle. done is never high for a requester other than the owner.
- Requests arriving during CALC are not acknowledged. They wait and are arbitrated at the next IDLE edge.
- A simultaneous new request and completion is impossible at the same edge, because completion returns the block to IDLE and acceptance happens one edge later.

## Test plan
- Reset: all outputs 0. Assert reset_n low mid-CALC: busy and done drop immediately, and no done pulse follows.
- Multiply, N=3, requester 0: a0=7, b0=7, op=0 -> gnt=01 one cycle, done=01 exactly 3 cycles after gnt, hi=6, lo=1, dz=0.
- Divide, requester 1: a1=7, b1=2, op=1 -> done=10, hi=1, lo=3, dz=0. Divide 5/0 -> hi=5, lo=7, dz=1.
- Contention: both req high immediately after reset -> requester 0 granted first. Requester 1 is granted at the first IDLE edge after requester 0's done. Both raise req again -> requester 0 wins (alternation).
- Operand hold: change a0/b0 in the cycle after gnt -> the result reflects the latched values (3*5 gives hi=1, lo=7).
- Exhaustive sweep: all a,b in 0..7 for both ops on both requesters -> {hi,lo} matches a*b, or {a%b, a/b} for b≠0. Each case completes in N+1 cycles from IDLE.
